// File: rtl/fast_square_pkg.sv
// Shared constants and helpers for the fast_square receive path: entry format
// and the marker words the host uses to delimit per-step frames.
package fast_square_pkg;

    localparam int          ENTRY_W    = 32;
    localparam logic [15:0] SYNC_WORD  = 16'hA5A5;
    localparam logic [15:0] TRAIL_WORD = 16'h5A5A;
    localparam logic [15:0] IDLE_WORD  = 16'h8000;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_TRL,
        SRC_HDR,
        SRC_SMP
    } push_src_e;

    // Q half of a header: frame_cnt in [15:8], step_idx in [7:0]
    function automatic logic [ENTRY_W-1:0] make_header(input logic [7:0] frame,
                                                       input logic [7:0] step);
        return {SYNC_WORD, frame, step};
    endfunction

endpackage

// File: rtl/fast_square_fifo.sv
// Single-clock first-word-fall-through FIFO; a pop frees a slot for a push
// in the same cycle, so a full FIFO can still accept while draining.
module fast_square_fifo #(
    parameter int LOG2 = 4,
    parameter int W    = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LOG2:0] level
);
    localparam int DEPTH = 2 ** LOG2;

    logic [W-1:0]    r_mem [DEPTH];
    logic [LOG2-1:0] r_wr_ptr;
    logic [LOG2-1:0] r_rd_ptr;
    logic [LOG2:0]   r_level;
    logic            w_do_pop;
    logic            w_do_push;

    assign full      = (r_level == (LOG2+1)'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + LOG2'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + LOG2'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (LOG2+1)'(1);
                2'b01:   r_level <= r_level - (LOG2+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/fast_square_frame_packer.sv
// Frames the per-step recorded I/Q stream (header, samples, trailer) into a
// FIFO and drains one entry per consumer strobe, idle word when empty.
module fast_square_frame_packer
    import fast_square_pkg::*;
#(
    parameter int NUM_FREQ_STEPS = 34,
    parameter int FIFO_LOG2      = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 step_reset,
    input  logic                 rx_next,
    input  logic                 rx_record,
    input  logic                 in_strobe,
    input  logic [15:0]          i_in,
    input  logic [15:0]          q_in,
    input  logic                 out_strobe,
    input  logic                 clear_status,
    output logic [15:0]          i_out,
    output logic [15:0]          q_out,
    output logic                 overflow,
    output logic [7:0]           step_idx,
    output logic [FIFO_LOG2:0]   fifo_level
);
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic               r_skid_vld;
    logic [ENTRY_W-1:0] r_skid;
    logic               r_rec_d;
    logic               r_hdr_pend;
    logic               r_trl_pend;
    logic [7:0]         r_step;
    logic [7:0]         r_frame;
    logic [15:0]        r_sample_cnt;
    logic               r_ovf;
    logic [15:0]        r_i_out;
    logic [15:0]        r_q_out;

    push_src_e          w_src;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_collide;
    logic               w_load;

    // Trailer before header so a step is closed before the next one opens
    always_comb begin
        w_src       = SRC_NONE;
        w_push_data = r_skid;
        if (r_trl_pend) begin
            w_src       = SRC_TRL;
            w_push_data = {TRAIL_WORD, r_sample_cnt};
        end else if (r_hdr_pend) begin
            w_src       = SRC_HDR;
            w_push_data = make_header(r_frame, r_step);
        end else if (r_skid_vld) begin
            w_src       = SRC_SMP;
        end
    end

    assign w_push    = (w_src != SRC_NONE);
    assign w_pop     = out_strobe & ~w_empty;
    assign w_accept  = w_push & (~w_full | w_pop);
    assign w_collide = in_strobe & rx_record & r_skid_vld;
    assign w_load    = in_strobe & rx_record & ~r_skid_vld;

    fast_square_fifo #(.LOG2(FIFO_LOG2), .W(ENTRY_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_skid_vld   <= 1'b0;
            r_rec_d      <= 1'b0;
            r_hdr_pend   <= 1'b0;
            r_trl_pend   <= 1'b0;
            r_step       <= '0;
            r_frame      <= '0;
            r_sample_cnt <= '0;
            r_ovf        <= 1'b0;
            r_i_out      <= IDLE_WORD;
            r_q_out      <= IDLE_WORD;
        end else begin
            r_rec_d    <= rx_record;
            r_skid_vld <= (r_skid_vld & (w_src != SRC_SMP)) | w_load;
            r_trl_pend <= (r_trl_pend & (w_src != SRC_TRL)) | (r_rec_d & ~rx_record);
            r_hdr_pend <= (r_hdr_pend & (w_src != SRC_HDR)) | rx_next;

            if (step_reset) begin
                r_step <= '0;
            end else if (rx_next) begin
                if (r_step == 8'(NUM_FREQ_STEPS - 1)) begin
                    r_step  <= '0;
                    r_frame <= r_frame + 8'd1;
                end else begin
                    r_step <= r_step + 8'd1;
                end
            end

            // A dropped sample is consumed from the skid but not counted
            if (w_src == SRC_HDR)
                r_sample_cnt <= '0;
            else if (w_src == SRC_SMP && w_accept)
                r_sample_cnt <= sat_inc16(r_sample_cnt);

            if ((w_push & ~w_accept) | w_collide)
                r_ovf <= 1'b1;
            else if (clear_status)
                r_ovf <= 1'b0;

            if (out_strobe) begin
                if (!w_empty) begin
                    r_i_out <= w_head[31:16];
                    r_q_out <= w_head[15:0];
                end else begin
                    r_i_out <= IDLE_WORD;
                    r_q_out <= IDLE_WORD;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_load) r_skid <= {i_in, q_in};
    end

    assign i_out    = r_i_out;
    assign q_out    = r_q_out;
    assign overflow = r_ovf;
    assign step_idx = r_step;

endmodule

// File: tb/tb_fast_square_frame_packer.sv
// Directed bench for fast_square_frame_packer: queue-based frame model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_fast_square_frame_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        step_reset = 1'b0;
    logic        rx_next = 1'b0;
    logic        rx_record = 1'b0;
    logic        in_strobe = 1'b0;
    logic [15:0] i_in = '0;
    logic [15:0] q_in = '0;
    logic        out_strobe = 1'b0;
    logic        clear_status = 1'b0;
    logic [15:0] i_out;
    logic [15:0] q_out;
    logic        overflow;
    logic [7:0]  step_idx;
    logic [4:0]  fifo_level;

    int checks = 0;
    int failures = 0;

    fast_square_frame_packer #(.NUM_FREQ_STEPS(34), .FIFO_LOG2(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .step_reset   (step_reset),
        .rx_next      (rx_next),
        .rx_record    (rx_record),
        .in_strobe    (in_strobe),
        .i_in         (i_in),
        .q_in         (q_in),
        .out_strobe   (out_strobe),
        .clear_status (clear_status),
        .i_out        (i_out),
        .q_out        (q_out),
        .overflow     (overflow),
        .step_idx     (step_idx),
        .fifo_level   (fifo_level)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending header/trailer, one-sample skid, bounded queue
    logic [31:0] mq[$];
    bit          m_hdr, m_trl, m_skv, m_rec_d, m_ovf;
    logic [31:0] m_sk;
    int          m_step, m_frame, m_cnt;
    logic [31:0] m_out;

    task automatic model_reset();
        mq.delete();
        m_hdr = 0; m_trl = 0; m_skv = 0; m_rec_d = 0; m_ovf = 0;
        m_sk = '0; m_step = 0; m_frame = 0; m_cnt = 0;
        m_out = 32'h80008000;
    endtask

    task automatic model_clock();
        int          src;
        logic [31:0] ent;
        bit          acc, coll;
        src = 0;
        ent = '0;
        if (out_strobe) m_out = (mq.size() > 0) ? mq.pop_front() : 32'h80008000;
        if (m_trl)      begin src = 1; ent = {16'h5A5A, m_cnt[15:0]}; end
        else if (m_hdr) begin src = 2; ent = {16'hA5A5, m_frame[7:0], m_step[7:0]}; end
        else if (m_skv) begin src = 3; ent = m_sk; end
        acc  = (src != 0) && (mq.size() < 16);
        if (acc) mq.push_back(ent);
        coll = in_strobe && rx_record && m_skv;
        if ((src != 0 && !acc) || coll) m_ovf = 1;
        else if (clear_status)          m_ovf = 0;
        if (src == 2) m_cnt = 0;
        else if (src == 3 && acc && m_cnt < 65535) m_cnt++;
        if (src == 1) m_trl = 0;
        if (src == 2) m_hdr = 0;
        if (src == 3) m_skv = 0;
        if (m_rec_d && !rx_record) m_trl = 1;
        if (rx_next) m_hdr = 1;
        m_rec_d = rx_record;
        if (in_strobe && rx_record && !coll) begin m_skv = 1; m_sk = {i_in, q_in}; end
        if (step_reset) m_step = 0;
        else if (rx_next) begin
            if (m_step == 33) begin m_step = 0; m_frame = (m_frame + 1) % 256; end
            else m_step++;
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else       model_clock();
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("cyc_out",   {i_out, q_out},      m_out);
            chk("cyc_ovf",   {31'd0, overflow},   {31'd0, m_ovf});
            chk("cyc_step",  {24'd0, step_idx},   {24'd0, m_step[7:0]});
            chk("cyc_level", {27'd0, fifo_level}, mq.size());
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic drain(output logic [31:0] v);
        out_strobe = 1'b1;
        @(negedge clock);
        out_strobe = 1'b0;
        v = {i_out, q_out};
    endtask

    task automatic sample(input logic [15:0] iv, input logic [15:0] qv);
        in_strobe = 1'b1; i_in = iv; q_in = qv;
        cyc();
        in_strobe = 1'b0;
        cyc();
    endtask

    task automatic pulse_next();
        rx_next = 1'b1;
        cyc();
        rx_next = 1'b0;
    endtask

    logic [31:0] v;
    logic [15:0] kk;

    initial begin
        cyc(3);
        reset = 1'b0;
        chk("rst_out",   {i_out, q_out}, 32'h80008000);
        chk("rst_ovf",   {31'd0, overflow}, 32'd0);
        chk("rst_step",  {24'd0, step_idx}, 32'd0);
        chk("rst_level", {27'd0, fifo_level}, 32'd0);

        for (int n = 0; n < 3; n++) begin
            drain(v);
            chk("idle_out", v, 32'h80008000);
        end
        chk("idle_ovf", {31'd0, overflow}, 32'd0);

        // One frame of four samples
        rx_record = 1'b1;
        pulse_next();
        for (int k = 1; k <= 4; k++) sample(16'(k), 16'(k));
        rx_record = 1'b0;
        cyc(3);
        drain(v); chk("f1_header", v, 32'hA5A50001);
        for (int k = 1; k <= 4; k++) begin
            drain(v); chk("f1_sample", v, {16'(k), 16'(k)});
        end
        drain(v); chk("f1_trailer", v, 32'h5A5A0004);
        drain(v); chk("f1_idle", v, 32'h80008000);

        // Step wrap across a full sweep
        step_reset = 1'b1;
        cyc();
        step_reset = 1'b0;
        for (int n = 1; n <= 34; n++) begin
            pulse_next();
            cyc();
            drain(v);
            if (n == 1)  chk("wrap_hdr1",  v, 32'hA5A50001);
            if (n == 33) chk("wrap_hdr33", v, 32'hA5A50021);
            if (n == 34) chk("wrap_hdr34", v, 32'hA5A50100);
        end
        chk("wrap_step", {24'd0, step_idx}, 32'd0);

        // Record falls together with the next step
        rx_record = 1'b1;
        pulse_next();
        sample(16'h0011, 16'h0011);
        sample(16'h0022, 16'h0022);
        rx_record = 1'b0;
        pulse_next();
        cyc(3);
        drain(v); chk("ord_hdr_a",   v, 32'hA5A50101);
        drain(v); chk("ord_smp1",    v, 32'h00110011);
        drain(v); chk("ord_smp2",    v, 32'h00220022);
        drain(v); chk("ord_trailer", v, 32'h5A5A0002);
        drain(v); chk("ord_hdr_b",   v, 32'hA5A50102);
        rx_record = 1'b1;
        cyc();
        rx_record = 1'b0;
        cyc(2);
        drain(v); chk("empty_trailer", v, 32'h5A5A0000);

        // step_reset and rx_next together
        step_reset = 1'b1;
        pulse_next();
        step_reset = 1'b0;
        cyc();
        drain(v); chk("sr_next_hdr", v, 32'hA5A50100);
        pulse_next();
        cyc();
        drain(v); chk("pre_fill_hdr", v, 32'hA5A50101);

        // Fill past depth without draining
        rx_record = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            kk = 16'(k);
            sample(kk, ~kk);
        end
        rx_record = 1'b0;
        cyc(3);
        chk("fill_level", {27'd0, fifo_level}, 32'd16);
        chk("fill_ovf",   {31'd0, overflow},   32'd1);
        clear_status = 1'b1;
        cyc();
        clear_status = 1'b0;
        chk("clear_ovf", {31'd0, overflow}, 32'd0);
        for (int k = 1; k <= 11; k++) begin
            kk = 16'(k);
            drain(v); chk("fill_drain", v, {kk, ~kk});
        end
        chk("pre_rst_level", {27'd0, fifo_level}, 32'd5);

        // Asynchronous reset in the middle of a drain
        out_strobe = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("arst_out",   {i_out, q_out}, 32'h80008000);
        chk("arst_level", {27'd0, fifo_level}, 32'd0);
        chk("arst_step",  {24'd0, step_idx}, 32'd0);
        cyc();
        out_strobe = 1'b0;
        reset = 1'b0;
        cyc();

        // Back-to-back strobes collide in the skid
        rx_record = 1'b1;
        in_strobe = 1'b1; i_in = 16'h0001; q_in = 16'h0001;
        cyc();
        i_in = 16'h0002; q_in = 16'h0002;
        cyc();
        in_strobe = 1'b0;
        cyc();
        chk("collide_ovf", {31'd0, overflow}, 32'd1);
        rx_record = 1'b0;
        cyc(3);
        drain(v); chk("collide_smp", v, 32'h00010001);
        drain(v); chk("collide_trl", v, 32'h5A5A0001);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
